wishbone_master_if: RTL and testbench

WISHBONE_MASTER_IF -- requirements
Module: wishbone_master_if

---
 rtl/wishbone_master_if.sv | 177 +++++++++++++++++
 tb/tb_wishbone_master_if.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_master_if.sv
// Wishbone classic master bridging the CPU memory port to the bus.
// Optional bus timeout abort is compiled in with `define WB_TIMEOUT_EN.
module wishbone_master_if #(
  parameter int DW             = 32,
  parameter int AW             = 32,
  parameter int STALL_W        = 6,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [STALL_W-1:0] stall_i,
  input  logic               flush_i,
  input  logic               cpu_ce_i,
  input  logic               cpu_we_i,
  input  logic [AW-1:0]      cpu_addr_i,
  input  logic [DW-1:0]      cpu_data_i,
  input  logic [DW/8-1:0]    cpu_sel_i,
  output logic [DW-1:0]      cpu_data_o,
  output logic               cpu_err_o,
  output logic               stallreq,
  input  logic [DW-1:0]      wishbone_data_i,
  input  logic               wishbone_ack_i,
  input  logic               wishbone_err_i,
  output logic [AW-1:0]      wishbone_addr_o,
  output logic [DW-1:0]      wishbone_data_o,
  output logic               wishbone_we_o,
  output logic [DW/8-1:0]    wishbone_sel_o,
  output logic               wishbone_stb_o,
  output logic               wishbone_cyc_o
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    WAIT_FOR_STALL
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdat_q, wdat_d;
  logic            we_q, we_d;
  logic [DW/8-1:0] sel_q, sel_d;
  logic            req_q, req_d;
  logic [DW-1:0]   dbuf_q, dbuf_d;
  logic            ebuf_q, ebuf_d;

  logic            tmo;
  logic            stall_c;
  logic [DW-1:0]   data_c;
  logic            err_c;

`ifdef WB_TIMEOUT_EN
  logic [15:0] tcnt_q;

  assign tmo = (state_q == BUSY) &&
               (tcnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q <= '0;
    end else if (state_q != BUSY) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_q + 16'd1;
    end
  end
`else
  logic unused_tmo_cfg;

  assign unused_tmo_cfg = (TIMEOUT_CYCLES == 0);
  assign tmo            = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    we_d    = we_q;
    sel_d   = sel_q;
    req_d   = req_q;
    dbuf_d  = dbuf_q;
    ebuf_d  = ebuf_q;
    stall_c = 1'b0;
    data_c  = '0;
    err_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_ce_i && !flush_i) begin
          stall_c = 1'b1;
          addr_d  = cpu_addr_i;
          wdat_d  = cpu_data_i;
          we_d    = cpu_we_i;
          sel_d   = cpu_sel_i;
          req_d   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (wishbone_err_i || wishbone_ack_i || tmo) begin
          addr_d  = '0;
          wdat_d  = '0;
          we_d    = 1'b0;
          sel_d   = '0;
          req_d   = 1'b0;
          state_d = (stall_i != '0) ? WAIT_FOR_STALL : IDLE;
          // err beats a simultaneous ack; timeout only without ack
          if (wishbone_err_i || !wishbone_ack_i) begin
            err_c  = 1'b1;
            ebuf_d = 1'b1;
          end else begin
            ebuf_d = 1'b0;
            if (!we_q) begin
              data_c = wishbone_data_i;
              dbuf_d = wishbone_data_i;
            end
          end
        end else if (flush_i) begin
          addr_d  = '0;
          wdat_d  = '0;
          we_d    = 1'b0;
          sel_d   = '0;
          req_d   = 1'b0;
          dbuf_d  = '0;
          ebuf_d  = 1'b0;
          state_d = IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      WAIT_FOR_STALL: begin
        data_c = dbuf_q;
        err_c  = ebuf_q;
        if (stall_i == '0) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdat_q  <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      req_q   <= 1'b0;
      dbuf_q  <= '0;
      ebuf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      req_q   <= req_d;
      dbuf_q  <= dbuf_d;
      ebuf_q  <= ebuf_d;
    end
  end

  // combinational outputs must read 0 while reset is held
  assign stallreq        = rst_n & stall_c;
  assign cpu_data_o      = rst_n ? data_c : '0;
  assign cpu_err_o       = rst_n & err_c;
  assign wishbone_addr_o = addr_q;
  assign wishbone_data_o = wdat_q;
  assign wishbone_we_o   = we_q;
  assign wishbone_sel_o  = sel_q;
  assign wishbone_stb_o  = req_q;
  assign wishbone_cyc_o  = req_q;

endmodule

// File: tb/tb_wishbone_master_if.sv
// Randomized bench for wishbone_master_if with a transaction-level model.
// Define WB_TIMEOUT_EN to also exercise the timeout abort (8 cycles).
module tb_wishbone_master_if;

`ifdef WB_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        cpu_ce_i;
  logic        cpu_we_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_data_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_data_o;
  logic        cpu_err_o;
  logic        stallreq;
  logic [31:0] wishbone_data_i;
  logic        wishbone_ack_i;
  logic        wishbone_err_i;
  logic [31:0] wishbone_addr_o;
  logic [31:0] wishbone_data_o;
  logic        wishbone_we_o;
  logic [3:0]  wishbone_sel_o;
  logic        wishbone_stb_o;
  logic        wishbone_cyc_o;

  int n_chk  = 0;
  int n_fail = 0;

  // transaction-level view of the held read data / error flag
  logic [31:0] dbuf_m;
  logic        ebuf_m;

  wishbone_master_if #(
    .DW(32), .AW(32), .STALL_W(6), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .stall_i(stall_i), .flush_i(flush_i),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_sel_i(cpu_sel_i),
    .cpu_data_o(cpu_data_o), .cpu_err_o(cpu_err_o),
    .stallreq(stallreq),
    .wishbone_data_i(wishbone_data_i),
    .wishbone_ack_i(wishbone_ack_i),
    .wishbone_err_i(wishbone_err_i),
    .wishbone_addr_o(wishbone_addr_o),
    .wishbone_data_o(wishbone_data_o),
    .wishbone_we_o(wishbone_we_o),
    .wishbone_sel_o(wishbone_sel_o),
    .wishbone_stb_o(wishbone_stb_o),
    .wishbone_cyc_o(wishbone_cyc_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bus_idle();
    chk("cyc_clr", 64'(wishbone_cyc_o), 0);
    chk("stb_clr", 64'(wishbone_stb_o), 0);
    chk("adr_clr", 64'(wishbone_addr_o), 0);
    chk("dat_clr", 64'(wishbone_data_o), 0);
    chk("we_clr", 64'(wishbone_we_o), 0);
    chk("sel_clr", 64'(wishbone_sel_o), 0);
  endtask

  // kind: 0 ack, 1 err, 2 ack+err, 3 flush, 4 timeout
  task automatic do_txn(input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] sel,
                        input int wait_n, input int kind,
                        input int stall_n, input logic [31:0] rd);
    int          nw;
    logic        e_err;
    logic [31:0] e_data;
    nw = (kind == 4) ? TMO - 1 : wait_n;
    cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = a;
    cpu_data_i = d; cpu_sel_i = sel; flush_i = 1'b0;
    wishbone_ack_i = 1'b0; wishbone_err_i = 1'b0;
    stall_i = 6'($urandom);
    @(negedge clk);
    chk("launch_stallreq", 64'(stallreq), 1);
    chk("launch_err", 64'(cpu_err_o), 0);
    chk("launch_data", 64'(cpu_data_o), 0);
    step();
    cpu_ce_i = 1'b0; cpu_addr_i = $urandom; cpu_data_i = $urandom;
    cpu_we_i = 1'($urandom); cpu_sel_i = 4'($urandom);
    for (int i = 0; i < nw; i++) begin
      wishbone_data_i = $urandom;
      stall_i = 6'($urandom);
      @(negedge clk);
      chk("busy_cyc", 64'(wishbone_cyc_o), 1);
      chk("busy_stb", 64'(wishbone_stb_o), 1);
      chk("busy_adr", 64'(wishbone_addr_o), 64'(a));
      chk("busy_dat", 64'(wishbone_data_o), 64'(d));
      chk("busy_we", 64'(wishbone_we_o), 64'(we));
      chk("busy_sel", 64'(wishbone_sel_o), 64'(sel));
      chk("busy_stallreq", 64'(stallreq), 1);
      chk("busy_data", 64'(cpu_data_o), 0);
      chk("busy_err", 64'(cpu_err_o), 0);
      step();
    end
    if (kind == 3) begin
      flush_i = 1'b1;
      @(negedge clk);
      chk("flush_stallreq", 64'(stallreq), 0);
      chk("flush_err", 64'(cpu_err_o), 0);
      chk("flush_data", 64'(cpu_data_o), 0);
      step();
      flush_i = 1'b0; wishbone_ack_i = 1'b1;
      wishbone_data_i = $urandom;
      dbuf_m = '0; ebuf_m = 1'b0;
      @(negedge clk);
      chk_bus_idle();
      chk("late_ack_stallreq", 64'(stallreq), 0);
      chk("late_ack_data", 64'(cpu_data_o), 0);
      chk("late_ack_err", 64'(cpu_err_o), 0);
      step();
      wishbone_ack_i = 1'b0;
    end else begin
      wishbone_data_i = rd;
      stall_i = (stall_n > 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      wishbone_ack_i = (kind == 0 || kind == 2);
      wishbone_err_i = (kind == 1 || kind == 2);
      e_err  = (kind != 0);
      e_data = (kind == 0 && !we) ? rd : 32'd0;
      @(negedge clk);
      chk("term_stallreq", 64'(stallreq), 0);
      chk("term_err", 64'(cpu_err_o), 64'(e_err));
      chk("term_data", 64'(cpu_data_o), 64'(e_data));
      if (e_err) begin
        ebuf_m = 1'b1;
      end else begin
        ebuf_m = 1'b0;
        if (!we) dbuf_m = rd;
      end
      step();
      wishbone_ack_i = 1'b0; wishbone_err_i = 1'b0;
      wishbone_data_i = $urandom;
      @(negedge clk);
      chk_bus_idle();
      if (stall_n == 0) begin
        chk("idle_data", 64'(cpu_data_o), 0);
        chk("idle_err", 64'(cpu_err_o), 0);
        chk("idle_stallreq", 64'(stallreq), 0);
        step();
      end else begin
        for (int i = 0; i < stall_n; i++) begin
          if (i > 0) @(negedge clk);
          chk("hold_data", 64'(cpu_data_o), 64'(dbuf_m));
          chk("hold_err", 64'(cpu_err_o), 64'(ebuf_m));
          chk("hold_stallreq", 64'(stallreq), 0);
          step();
          stall_i = (i == stall_n - 1) ? 6'd0 : 6'($urandom_range(1, 63));
          flush_i = 1'($urandom);
          wishbone_data_i = $urandom;
        end
        @(negedge clk);
        chk("rel_data", 64'(cpu_data_o), 64'(dbuf_m));
        chk("rel_err", 64'(cpu_err_o), 64'(ebuf_m));
        step();
        flush_i = 1'b0;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; stall_i = '0; flush_i = 1'b0;
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h40;
    cpu_data_i = '0; cpu_sel_i = 4'hf;
    wishbone_data_i = 32'h1234_5678;
    wishbone_ack_i = 1'b0; wishbone_err_i = 1'b0;
    dbuf_m = '0; ebuf_m = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stallreq", 64'(stallreq), 0);
    chk("rst_data", 64'(cpu_data_o), 0);
    chk("rst_err", 64'(cpu_err_o), 0);
    chk_bus_idle();
    cpu_ce_i = 1'b0;
    rst_n = 1'b1;
    step();

    // read, ack in the fourth BUSY cycle, no stall
    do_txn(1'b0, 32'h100, 32'h0, 4'hf, 3, 0, 0, 32'hDEAD_BEEF);
    // same read held by ctrl stall for three cycles
    do_txn(1'b0, 32'h100, 32'h0, 4'hf, 3, 0, 3, 32'hDEAD_BEEF);
    // write terminated by err
    do_txn(1'b1, 32'h200, 32'hCAFE_F00D, 4'b0011, 1, 1, 0, 32'h0);
    // flush abort then ignored late ack
    do_txn(1'b0, 32'h300, 32'h0, 4'hf, 1, 3, 0, 32'h0);
    // write ack with stall shows cleared buffers
    do_txn(1'b1, 32'h304, 32'h5555_AAAA, 4'hc, 0, 0, 2, 32'h0);
    // ack and err together act as err
    do_txn(1'b0, 32'h308, 32'h0, 4'hf, 2, 2, 1, 32'h0BAD_0BAD);
`ifdef WB_TIMEOUT_EN
    do_txn(1'b0, 32'h400, 32'h0, 4'hf, 0, 4, 1, 32'h0);
`endif

    // flush in IDLE suppresses launch
    cpu_ce_i = 1'b1; flush_i = 1'b1; stall_i = '0;
    @(negedge clk);
    chk("idle_flush_stallreq", 64'(stallreq), 0);
    step();
    cpu_ce_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    chk("idle_flush_cyc", 64'(wishbone_cyc_o), 0);
    step();

    // load a read value so reset clearing is visible
    do_txn(1'b0, 32'h500, 32'h0, 4'hf, 0, 0, 0, 32'h7777_1111);
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h600;
    step();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_cyc", 64'(wishbone_cyc_o), 0);
    chk("arst_stb", 64'(wishbone_stb_o), 0);
    chk("arst_stallreq", 64'(stallreq), 0);
    dbuf_m = '0; ebuf_m = 1'b0;
    @(negedge clk);
    cpu_ce_i = 1'b0;
    rst_n = 1'b1;
    step();
    do_txn(1'b1, 32'h604, 32'h1, 4'h1, 1, 0, 1, 32'h0);

    for (int t = 0; t < 200; t++) begin
`ifdef WB_TIMEOUT_EN
      do_txn(1'($urandom), $urandom, $urandom, 4'($urandom),
             $urandom_range(0, 5), $urandom_range(0, 4),
             $urandom_range(0, 3), $urandom);
`else
      do_txn(1'($urandom), $urandom, $urandom, 4'($urandom),
             $urandom_range(0, 5), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
